// File: rtl/cs_stream.sv
// -----------------------------------------------------------------------------
// cs_stream -- multi-channel streaming checksum engine
//
// Accepts packets of up to MAX_BEATS beats. Every beat carries NUM_CH
// independent channels of CH_W bits. Each channel is cut into CH_W/RES_W words.
// Those words are reduced in parallel into one accumulator per channel. After
// the last beat the accumulators are reduced once more and complemented, then
// presented for a single cycle.
//
// Algorithms (mode is sampled on the first beat only):
//   2'b00 / 2'b11 : two's-complement sum, result = -sum mod 2^RES_W
//   2'b01         : ones'-complement sum (end-around carry), result = ~sum
//   2'b10         : XOR of all words, result = xor
//
// Ports
//   clk        single rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   beat qualifier
//   in_data    beat payload, channel k = in_data[k*CH_W +: CH_W]
//   in_last    final beat of packet (qualified by in_valid)
//   mode       algorithm select, sampled on the first beat
//   in_ready   a beat offered this cycle is accepted
//   out_valid  one-cycle result strobe
//   result     checksum, channel k = result[k*RES_W +: RES_W]; 0 when idle
//   err        packet truncated at MAX_BEATS; 0 when out_valid is low
// -----------------------------------------------------------------------------
module cs_stream #(
    parameter int NUM_CH    = 2,
    parameter int CH_W      = 128,
    parameter int RES_W     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [NUM_CH*CH_W-1:0]    in_data,
    input  logic                      in_last,
    input  logic [1:0]                mode,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [NUM_CH*RES_W-1:0]   result,
    output logic                      err
);

    localparam int WORDS      = CH_W / RES_W;
    // Headroom so that MAX_BEATS * WORDS full-scale words never overflow.
    localparam int ACC_W      = RES_W + $clog2(MAX_BEATS * WORDS);
    localparam int CNT_W      = $clog2(MAX_BEATS + 1);
    // Each fold pass at least shrinks the value by RES_W bits; one extra pass
    // absorbs the carry the final addition can generate.
    localparam int FOLD_ITERS = (ACC_W + RES_W - 1) / RES_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        FOLD = 2'b10,
        OUT  = 2'b11
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Sum of all RES_W words of one channel slice, widened to ACC_W.
    function automatic logic [ACC_W-1:0] word_sum(input logic [CH_W-1:0] chunk);
        logic [ACC_W-1:0] acc_v;
        acc_v = {ACC_W{1'b0}};
        for (int w = 0; w < WORDS; w++) begin
            acc_v = acc_v + ACC_W'(chunk[w*RES_W +: RES_W]);
        end
        return acc_v;
    endfunction

    // XOR of all RES_W words of one channel slice.
    function automatic logic [RES_W-1:0] word_xor(input logic [CH_W-1:0] chunk);
        logic [RES_W-1:0] x_v;
        x_v = {RES_W{1'b0}};
        for (int w = 0; w < WORDS; w++) begin
            x_v = x_v ^ chunk[w*RES_W +: RES_W];
        end
        return x_v;
    endfunction

    // Fold one beat into a running accumulator. Modes 00, 01 and 11 all keep a
    // plain wide sum; the ones'-complement carry folding happens only at the end.
    function automatic logic [ACC_W-1:0] absorb(input logic [ACC_W-1:0] acc,
                                                input logic [1:0]       md,
                                                input logic [CH_W-1:0]  chunk);
        logic [ACC_W-1:0] r_v;
        if (md == 2'b10) begin
            r_v = acc ^ ACC_W'(word_xor(chunk));
        end else begin
            r_v = acc + word_sum(chunk);
        end
        return r_v;
    endfunction

    // Repeated end-around carry fold down to RES_W bits.
    function automatic logic [RES_W-1:0] ones_fold(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] t_v;
        t_v = v;
        for (int i = 0; i < FOLD_ITERS; i++) begin
            t_v = (t_v & ACC_W'({RES_W{1'b1}})) + (t_v >> RES_W);
        end
        return t_v[RES_W-1:0];
    endfunction

    // Final reduction / complement of one channel accumulator.
    function automatic logic [RES_W-1:0] finalize(input logic [ACC_W-1:0] acc,
                                                  input logic [1:0]       md);
        logic [RES_W-1:0] r_v;
        case (md)
            2'b01:   r_v = ~ones_fold(acc);
            2'b10:   r_v = acc[RES_W-1:0];
            default: r_v = (~acc[RES_W-1:0]) + RES_W'(1);
        endcase
        return r_v;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                    state_r;
    state_t                    state_next_s;
    logic [ACC_W-1:0]          acc_r      [NUM_CH];
    logic [ACC_W-1:0]          acc_next_s [NUM_CH];
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_next_s;
    logic [CNT_W-1:0]          cnt_inc_s;
    logic [1:0]                mode_r;
    logic [1:0]                mode_next_s;
    logic                      err_pend_r;
    logic                      err_next_s;
    logic                      accept_s;
    logic [NUM_CH*RES_W-1:0]   fold_res_s;

    logic                      in_ready_r;
    logic                      out_valid_r;
    logic [NUM_CH*RES_W-1:0]   result_r;
    logic                      err_r;

    assign accept_s  = in_valid & in_ready_r;
    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Next-state, accumulator, counter and latched-mode logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        mode_next_s  = mode_r;
        err_next_s   = err_pend_r;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc_next_s[ch] = acc_r[ch];
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    // First beat: latch mode and restart accumulation from zero.
                    mode_next_s = mode;
                    cnt_next_s  = CNT_W'(1);
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        acc_next_s[ch] = absorb({ACC_W{1'b0}}, mode,
                                                in_data[ch*CH_W +: CH_W]);
                    end
                    if (in_last || (CNT_W'(1) == CNT_W'(MAX_BEATS))) begin
                        state_next_s = FOLD;
                        err_next_s   = ~in_last;
                    end else begin
                        state_next_s = ACC;
                        err_next_s   = 1'b0;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACC: begin
                if (accept_s) begin
                    cnt_next_s = cnt_inc_s;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        acc_next_s[ch] = absorb(acc_r[ch], mode_r,
                                                in_data[ch*CH_W +: CH_W]);
                    end
                    // Hitting the beat limit without in_last closes the packet
                    // and flags it as truncated.
                    if (in_last || (cnt_inc_s == CNT_W'(MAX_BEATS))) begin
                        state_next_s = FOLD;
                        err_next_s   = ~in_last;
                    end else begin
                        state_next_s = ACC;
                    end
                end else begin
                    state_next_s = ACC;
                end
            end
            FOLD: begin
                state_next_s = OUT;
            end
            OUT: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Final per-channel reduction, evaluated while in FOLD.
    always_comb begin
        fold_res_s = {(NUM_CH*RES_W){1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            fold_res_s[ch*RES_W +: RES_W] = finalize(acc_r[ch], mode_r);
        end
    end

    // Core state, accumulators, beat counter and latched mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            mode_r     <= 2'b00;
            err_pend_r <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_r[ch] <= {ACC_W{1'b0}};
            end
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            mode_r     <= mode_next_s;
            err_pend_r <= err_next_s;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc_r[ch] <= acc_next_s[ch];
            end
        end
    end

    // Registered outputs: the FOLD result is captured on the edge into OUT so
    // out_valid/result/err are high for exactly the OUT cycle and zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {(NUM_CH*RES_W){1'b0}};
            err_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == IDLE) || (state_next_s == ACC);
            out_valid_r <= (state_r == FOLD);
            result_r    <= (state_r == FOLD) ? fold_res_s : {(NUM_CH*RES_W){1'b0}};
            err_r       <= (state_r == FOLD) ? err_pend_r : 1'b0;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign err       = err_r;

endmodule

// File: tb/tb_cs_stream.sv
// -----------------------------------------------------------------------------
// tb_cs_stream -- scoreboard bench for cs_stream (default parameters).
// The driver pushes the hand-computed result, err and expected out_valid cycle
// when the last beat of a packet is accepted; an independent monitor pops and
// compares whenever out_valid is seen, and checks outputs are zero otherwise.
// -----------------------------------------------------------------------------
module tb_cs_stream;

    localparam int NUM_CH    = 2;
    localparam int CH_W      = 128;
    localparam int RES_W     = 8;
    localparam int MAX_BEATS = 16;
    localparam int DW        = NUM_CH * CH_W;
    localparam int RW        = NUM_CH * RES_W;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [1:0]    mode     = 2'b00;
    logic          in_ready;
    logic          out_valid;
    logic [RW-1:0] result;
    logic          err;

    typedef struct {
        logic [RW-1:0] res;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    cs_stream #(
        .NUM_CH   (NUM_CH),
        .CH_W     (CH_W),
        .RES_W    (RES_W),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .mode     (mode),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .result   (result),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one beat; returns the cycle count seen just before the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [1:0] m,
                             output int acc_cyc);
        int waits;
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode     = m;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end
        acc_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic push_exp(input logic [RW-1:0] r, input logic e, input int acc_cyc);
        exp_t x;
        x.res = r;
        x.err = e;
        x.cyc = acc_cyc + 2;
        sb.push_back(x);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Call right after the last beat's accepting edge: FOLD then OUT, both busy.
    task automatic busy_check(input bit junk);
        @(negedge clk);
        in_valid = junk;
        in_data  = '1;
        in_last  = 1'b1;
        check("ready_low_fold", in_ready, 0);
        @(negedge clk);
        check("ready_low_out", in_ready, 0);
        check("out_valid_in_out", out_valid, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: pops an expectation on every out_valid, else requires zero outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", result, mon_e.res);
                    check("err", err, mon_e.err);
                    check("out_valid_cycle", cyc, mon_e.cyc);
                end
            end else begin
                check("idle_outputs_zero", {result, err}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d_ones01;
        logic [DW-1:0] d_ff_ch1;
        int c;
        int c2;

        d_ones01 = {128'h0, {16{8'h01}}};
        d_ff_ch1 = {120'h0, 8'h01, {16{8'hFF}}};

        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Two's complement, single beat: 16*0x01 -> 0xF0
        send_beat(d_ones01, 1'b1, 2'b00, c);
        push_exp(16'h00F0, 1'b0, c);
        go_idle();

        // Ones' complement: ch0 16*0xFF folds to 0xFF -> 0x00; ch1 sum 1 -> 0xFE
        send_beat(d_ff_ch1, 1'b1, 2'b01, c);
        push_exp(16'hFE00, 1'b0, c);
        go_idle();

        // Ones' complement end-around carry: 0xFF+0x02=0x101 -> 0x02 -> 0xFD; ch1 ~0
        send_beat({128'h0, 112'h0, 8'h02, 8'hFF}, 1'b1, 2'b01, c);
        push_exp(16'hFFFD, 1'b0, c);
        go_idle();

        // XOR over three beats, mode changed after first beat
        send_beat({248'h0, 8'hA5}, 1'b0, 2'b10, c);
        send_beat('0, 1'b0, 2'b00, c);
        send_beat('0, 1'b1, 2'b00, c);
        push_exp(16'h00A5, 1'b0, c);
        busy_check(1'b0);

        // Reserved mode 11 behaves as two's complement
        send_beat({{16{8'h01}}, 120'h0, 8'h03}, 1'b1, 2'b11, c);
        push_exp(16'hF0FD, 1'b0, c);
        go_idle();

        // Truncation at MAX_BEATS without in_last; junk offered while busy
        for (int i = 0; i < MAX_BEATS; i++) begin
            send_beat(d_ones01, 1'b0, 2'b00, c);
        end
        push_exp(16'h0000, 1'b1, c);
        busy_check(1'b1);

        // in_last on beat MAX_BEATS -> no error
        for (int i = 0; i < MAX_BEATS; i++) begin
            send_beat(d_ones01, (i == MAX_BEATS - 1) ? 1'b1 : 1'b0, 2'b00, c);
        end
        push_exp(16'h0000, 1'b0, c);
        go_idle();
        repeat (3) @(negedge clk);

        // Reset mid-packet discards it
        send_beat(d_ones01, 1'b0, 2'b00, c);
        send_beat(d_ones01, 1'b0, 2'b00, c);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_err", err, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_beat(d_ones01, 1'b1, 2'b00, c);
        push_exp(16'h00F0, 1'b0, c);
        go_idle();

        // Back-to-back with in_valid held high
        send_beat(d_ones01, 1'b1, 2'b00, c);
        push_exp(16'h00F0, 1'b0, c);
        send_beat(d_ff_ch1, 1'b1, 2'b01, c2);
        push_exp(16'hFE00, 1'b0, c2);
        check("b2b_accept_cycle", c2, c + 3);
        go_idle();

        repeat (6) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cs_stream.md
CS_STREAM -- requirements
Module: cs_stream

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent checksum channels.
REQ-002 Parameter CH_W, default 128: bits per channel per beat; SHALL be a multiple of RES_W.
REQ-003 Parameter RES_W, default 8: word width and checksum result width per channel.
REQ-004 Parameter MAX_BEATS, default 16: maximum beats per packet; must be >= 1.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  beat qualifier.
REQ-008 in_data  input  NUM_CH*CH_W  beat payload; channel k = bits [k*CH_W +: CH_W].
REQ-009 in_last  input  1  marks final beat of packet; qualified by in_valid.
REQ-010 mode  input  2  algorithm select; sampled on first beat only.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 out_valid  output  1  one-cycle result strobe.
REQ-013 result  output  NUM_CH*RES_W  checksum; channel k = bits [k*RES_W +: RES_W].
REQ-014 err  output  1  packet truncated at MAX_BEATS; valid with out_valid.

Function
REQ-015 Beat accepted SHALL mean in_valid & in_ready at rising clk.
REQ-016 FSM states SHALL be IDLE, ACC, FOLD, OUT.
REQ-017 IDLE: in_ready=1; accepted beat -> latch mode, clear accumulators, absorb beat, beat count=1; in_last or count==MAX_BEATS -> FOLD, else ACC.
REQ-018 ACC: in_ready=1; each accepted beat absorbed, count+1; in_last or count reaches MAX_BEATS -> FOLD; no beat -> stay ACC indefinitely.
REQ-019 FOLD: in_ready=0; one cycle, final reduction/complement; -> OUT.
REQ-020 OUT: in_ready=0, out_valid=1, result/err driven for exactly one cycle; -> IDLE.
REQ-021 Latency: out_valid SHALL rise 2 cycles after the clk edge accepting the last beat; next packet accepted earliest 1 cycle after out_valid.
REQ-022 in_valid while in_ready=0 SHALL be ignored (data dropped, no state change).
REQ-023 Each channel splits its CH_W bits into CH_W/RES_W words, summed per beat in parallel.
REQ-024 mode 00: two's-complement sum mod 2^RES_W, result = (~sum)+1 (packet plus checksum sums to zero).
REQ-025 mode 01: ones'-complement sum with end-around carry, result = ~sum.
REQ-026 mode 10: bitwise XOR of all words, result = xor.
REQ-027 mode 11: reserved, SHALL behave as 00.
REQ-028 Accumulators SHALL be wide enough (RES_W + clog2(MAX_BEATS*CH_W/RES_W) bits) that no carry is lost before FOLD; ones'-complement folding repeated until no carry remains.
REQ-029 Mode changes after first beat SHALL not affect the current packet.
REQ-030 Beat MAX_BEATS without in_last SHALL be treated as last, err=1, result computed over the MAX_BEATS beats; in_last on that beat gives err=0.
REQ-031 result and err SHALL be 0 whenever out_valid=0.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0, err=0, accumulators, count and latched mode to 0.
REQ-033 Reset mid-packet (ACC/FOLD/OUT) SHALL discard the packet; no out_valid for it; first accepted beat after release starts a new packet.

Verification
REQ-034 mode 00, one beat, ch0 all bytes 0x01, ch1 all 0x00, in_last=1 -> out_valid 2 cycles later, result={ch1 0x00, ch0 0xF0}, err=0.
REQ-035 mode 01, one beat, ch0 all bytes 0xFF, ch1 byte0=0x01 rest 0 -> result ch0=0x00, ch1=0xFE.
REQ-036 mode 10, three beats, ch0 byte0=0xA5 on beat 1 only, others 0; mode driven 00 on beats 2-3 -> ch0=0xA5, ch1=0x00, out_valid once, in_ready low during FOLD/OUT.
REQ-037 mode 00, 16 beats ch0 all 0x01, in_last never asserted -> on beat 16 accept, out_valid 2 cycles later, err=1, ch0=0x00 (256 mod 256 negated), in_valid during FOLD/OUT ignored.
REQ-038 rst pulse after beat 2 of a 4-beat packet -> all outputs 0 during reset, no out_valid; fresh single-beat packet from REQ-034 then gives ch0=0xF0.
REQ-039 Back-to-back: two single-beat packets with in_valid held high -> second beat accepted only in cycle after first out_valid; both results correct.
